// File: rtl/ikaopll_dac_frame_rx.sv
// Receive-side frame assembler for the OPLL DAC sample stream.
// Tracks the 18-tick master frame and reports saturated per-frame music/rhythm sums.
module ikaopll_dac_frame_rx #(
  parameter int DATA_WIDTH = 9,
  parameter int SUM_WIDTH  = 13
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_RST_n,
  input  logic                        i_phi1_NCEN_n,
  input  logic                        i_CYCLE_00,
  input  logic                        i_MO_CTRL,
  input  logic                        i_RO_CTRL,
  input  logic signed [DATA_WIDTH-1:0] i_DATA,
  output logic signed [SUM_WIDTH-1:0]  o_MO_SUM,
  output logic signed [SUM_WIDTH-1:0]  o_RO_SUM,
  output logic [4:0]                  o_MO_CNT,
  output logic [4:0]                  o_RO_CNT,
  output logic                        o_SAMPLE_VALID,
  output logic                        o_FRAME_ERR,
  output logic                        o_SAT,
  output logic                        o_LOCKED
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  localparam logic [4:0]           CNT_MAX = 5'd31;
  localparam logic [4:0]           TCNT_LAST = 5'd17;

  state_t r_state;
  state_t w_next_state;

  logic [4:0]           r_tcnt;
  logic [SUM_WIDTH-1:0] r_mo_acc;
  logic [SUM_WIDTH-1:0] r_ro_acc;
  logic [4:0]           r_mo_cnt;
  logic [4:0]           r_ro_cnt;
  logic                 r_sat;

  logic                 w_tick;
  logic                 w_frame_close;
  logic                 w_keep;
  logic                 w_restart;
  logic [SUM_WIDTH-1:0] w_data_ext;
  logic [SUM_WIDTH-1:0] w_mo_base;
  logic [SUM_WIDTH-1:0] w_ro_base;
  logic [4:0]           w_mo_cnt_base;
  logic [4:0]           w_ro_cnt_base;
  logic [SUM_WIDTH-1:0] w_mo_next;
  logic [SUM_WIDTH-1:0] w_ro_next;
  logic [4:0]           w_mo_cnt_next;
  logic [4:0]           w_ro_cnt_next;
  logic                 w_mo_clamp;
  logic                 w_ro_clamp;
  logic                 w_sat_next;
  logic [SUM_WIDTH:0]   w_mo_add;
  logic [SUM_WIDTH:0]   w_ro_add;

  // Returns {clamped, result}; overflow shows as disagreement of the two top bits.
  function automatic logic [SUM_WIDTH:0] satAdd(input logic [SUM_WIDTH-1:0] a,
                                                input logic [SUM_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] wide;
    wide = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
    if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1]) begin
      return {1'b1, (wide[SUM_WIDTH] ? SUM_MIN : SUM_MAX)};
    end
    return {1'b0, wide[SUM_WIDTH-1:0]};
  endfunction

  function automatic logic [4:0] cntInc(input logic [4:0] c);
    return (c == CNT_MAX) ? c : c + 5'd1;
  endfunction

  assign w_tick     = ~i_phi1_NCEN_n;
  assign w_data_ext = {{(SUM_WIDTH-DATA_WIDTH){i_DATA[DATA_WIDTH-1]}}, i_DATA};

  always_comb begin
    w_next_state  = r_state;
    w_frame_close = 1'b0;
    unique case (r_state)
      ST_UNLOCKED: begin
        if (w_tick && i_CYCLE_00) begin
          w_next_state = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_tick) begin
          if (i_CYCLE_00) begin
            w_frame_close = 1'b1;
          end else if (r_tcnt == CNT_MAX) begin
            w_next_state = ST_UNLOCKED;
          end
        end
      end
      default: w_next_state = ST_UNLOCKED;
    endcase
  end

  // A sync tick starts a fresh frame, so its own sample seeds the accumulators.
  always_comb begin
    w_keep        = (w_next_state == ST_LOCKED);
    w_restart     = i_CYCLE_00;
    w_mo_base     = w_restart ? '0 : r_mo_acc;
    w_ro_base     = w_restart ? '0 : r_ro_acc;
    w_mo_cnt_base = w_restart ? 5'd0 : r_mo_cnt;
    w_ro_cnt_base = w_restart ? 5'd0 : r_ro_cnt;
    w_mo_add      = satAdd(w_mo_base, w_data_ext);
    w_ro_add      = satAdd(w_ro_base, w_data_ext);
    w_mo_next     = w_mo_base;
    w_ro_next     = w_ro_base;
    w_mo_cnt_next = w_mo_cnt_base;
    w_ro_cnt_next = w_ro_cnt_base;
    w_mo_clamp    = 1'b0;
    w_ro_clamp    = 1'b0;
    if (i_MO_CTRL) begin
      w_mo_next     = w_mo_add[SUM_WIDTH-1:0];
      w_mo_clamp    = w_mo_add[SUM_WIDTH];
      w_mo_cnt_next = cntInc(w_mo_cnt_base);
    end
    if (i_RO_CTRL) begin
      w_ro_next     = w_ro_add[SUM_WIDTH-1:0];
      w_ro_clamp    = w_ro_add[SUM_WIDTH];
      w_ro_cnt_next = cntInc(w_ro_cnt_base);
    end
    w_sat_next = (w_restart ? 1'b0 : r_sat) | w_mo_clamp | w_ro_clamp;
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_tcnt   <= 5'd0;
      r_mo_acc <= '0;
      r_ro_acc <= '0;
      r_mo_cnt <= 5'd0;
      r_ro_cnt <= 5'd0;
      r_sat    <= 1'b0;
    end else if (w_tick) begin
      if (w_keep) begin
        r_tcnt   <= i_CYCLE_00 ? 5'd0 : r_tcnt + 5'd1;
        r_mo_acc <= w_mo_next;
        r_ro_acc <= w_ro_next;
        r_mo_cnt <= w_mo_cnt_next;
        r_ro_cnt <= w_ro_cnt_next;
        r_sat    <= w_sat_next;
      end else begin
        r_tcnt   <= 5'd0;
        r_mo_acc <= '0;
        r_ro_acc <= '0;
        r_mo_cnt <= 5'd0;
        r_ro_cnt <= 5'd0;
        r_sat    <= 1'b0;
      end
    end
  end

  // Output registers only move on a frame close; a loss of lock leaves them untouched.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      o_MO_SUM       <= '0;
      o_RO_SUM       <= '0;
      o_MO_CNT       <= 5'd0;
      o_RO_CNT       <= 5'd0;
      o_SAMPLE_VALID <= 1'b0;
      o_FRAME_ERR    <= 1'b0;
      o_SAT          <= 1'b0;
      o_LOCKED       <= 1'b0;
    end else begin
      o_SAMPLE_VALID <= w_frame_close;
      o_LOCKED       <= (w_next_state == ST_LOCKED);
      if (w_frame_close) begin
        o_MO_SUM    <= r_mo_acc;
        o_RO_SUM    <= r_ro_acc;
        o_MO_CNT    <= r_mo_cnt;
        o_RO_CNT    <= r_ro_cnt;
        o_FRAME_ERR <= (r_tcnt != TCNT_LAST);
        o_SAT       <= r_sat;
      end
    end
  end

endmodule

// File: doc/ikaopll_dac_frame_rx.md
# ikaopll_dac_frame_rx

Receive-side frame assembler for the time-multiplexed DAC sample stream that the OPLL core emits under the timing generator's MO/RO control strobes. It tracks the 18-phi1-cycle master frame from the cycle-0 strobe and accumulates each frame's music and rhythm samples into saturated signed sums. At each frame boundary it presents one music and one rhythm sample to downstream mixing and filtering, with per-frame sample counts and framing diagnostics. It sits between the core's sample output and the host-side audio mixer.

## Interface

- DATA_WIDTH, 9: width of the signed per-slot sample input.
- SUM_WIDTH, 13: width of the signed accumulated outputs; must be greater than DATA_WIDTH.

- i_EMUCLK  input  1  emulator master clock; all state changes on its rising edge.
- i_RST_n  input  1  reset; asynchronous and active-low.
- i_phi1_NCEN_n  input  1  phi1 tick enable, active-low; all frame logic advances only on ticks.
- i_CYCLE_00  input  1  master cycle 0 strobe; qualified by tick.
- i_MO_CTRL  input  1  current slot carries a music sample.
- i_RO_CTRL  input  1  current slot carries a rhythm sample.
- i_DATA  input  DATA_WIDTH  signed two's-complement slot sample.
- o_MO_SUM  output  SUM_WIDTH  last completed frame's music sum.
- o_RO_SUM  output  SUM_WIDTH  last completed frame's rhythm sum.
- o_MO_CNT  output  5  number of music samples in the last frame.
- o_RO_CNT  output  5  number of rhythm samples in the last frame.
- o_SAMPLE_VALID  output  1  one-EMUCLK pulse when the outputs update.
- o_FRAME_ERR  output  1  high with the valid pulse if the last frame length was not 18 ticks; held until the next update.
- o_SAT  output  1  last frame's music or rhythm sum saturated; held until the next update.
- o_LOCKED  output  1  frame tracker synchronised.

## Operation

- Tick: an EMUCLK edge at which i_phi1_NCEN_n is 0. Non-tick edges change nothing except clearing o_SAMPLE_VALID.
- State: UNLOCKED and LOCKED. Internal registers: tick counter tcnt[4:0], music and rhythm accumulators, two 5-bit sample counters, and a sticky saturation flag.
- UNLOCKED:
  - Accumulators, counters and tcnt are held at 0.
  - On a tick with i_CYCLE_00=1, go to LOCKED with tcnt=0. The accumulators load this tick's contribution. No output update.
- LOCKED, tick with i_CYCLE_00=0:
  - tcnt += 1.
  - If i_MO_CTRL=1, the music accumulator adds sign-extended i_DATA and the music count increments.
  - If i_RO_CTRL=1, the same applies to the rhythm accumulator and count.
  - Both strobes high: add to both.
- LOCKED, tick with i_CYCLE_00=1 (frame close):
  - Sums, counts and the saturation flag transfer to the outputs.
  - o_FRAME_ERR = (tcnt != 17).
  - o_SAMPLE_VALID pulses.
  - Accumulators, counts and the saturation flag restart from this tick's contribution only. tcnt=0.
- Loss of lock: in LOCKED, a tick that would advance tcnt past 31 without i_CYCLE_00 moves the block to UNLOCKED. It clears all internal state. o_LOCKED drops and there is no valid pulse. Output registers keep their last values.
- Arithmetic: each accumulate saturates to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1]. Any clamp sets the frame's saturation flag. Counters saturate at 31.
- Reset (any time, including mid-frame): UNLOCKED. All outputs are 0; o_LOCKED=0.

## Timing

- All outputs are registered.
- Frame-close latency: outputs and o_SAMPLE_VALID change at the same EMUCLK edge that samples the closing tick. o_SAMPLE_VALID is high for exactly one EMUCLK period after that edge.
- o_LOCKED rises at the edge sampling the first qualified cycle-0 tick. It falls at the edge sampling the 32nd tick without sync.
- The sample on the closing tick belongs to the new frame, never to the reported one.
- The first valid pulse after lock comes at the second qualified cycle-0 tick.
- A de-asserted i_RST_n takes effect without a clock edge. Release is sampled at the next EMUCLK edge.

## Test plan

- Reset: assert i_RST_n=0 mid-frame → all outputs 0 and o_LOCKED=0 immediately. After release, the first frame close produces no valid pulse.
- Nominal frame: after lock, 18-tick frame with i_MO_CTRL on 9 ticks (i_DATA=10) and i_RO_CTRL on 5 ticks (i_DATA=-3) → o_MO_SUM=90, o_RO_SUM=-15, counts 9/5, o_FRAME_ERR=0, o_SAT=0, one valid pulse.
- Saturation: 18 music ticks with i_DATA=+255 → o_MO_SUM=4095, o_SAT=1. Then 18 music ticks with i_DATA=-256 → o_MO_SUM=-4096, o_SAT=1. A following clean frame with data 1 on all 18 ticks → o_MO_SUM=18, o_SAT=0.
- Boundary sample: i_CYCLE_00 and i_MO_CTRL on the same tick with i_DATA=7 → the reported sum excludes 7; the next frame's sum includes 7.
- Framing error: sync after 10 ticks → valid pulse with o_FRAME_ERR=1 and the partial sums reported. A following 18-tick frame → o_FRAME_ERR=0.
- Lock loss: 32 ticks without sync → o_LOCKED=0 with no valid pulse and outputs unchanged. The next sync relocks, and valid returns one frame later.
